// File: rtl/ram_fifo_pkg.sv
// Shared constants and width helpers for the RAM-backed FIFO controller.
// Latency: none (package only).
// Backpressure: n/a.
package ram_fifo_pkg;

    // Output buffer depth: one entry being popped plus one read returning.
    localparam int OB_DEPTH = 2;

    // Bits needed to count 0..OB_DEPTH inside the output buffer.
    localparam int OB_CNT_W = $clog2(OB_DEPTH + 1);

    // Pointer width: address bits plus one wrap bit so full and empty differ.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Total-count width: covers DEPTH + OB_DEPTH entries with headroom.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/ram_fifo_ob.sv
// Two-entry output buffer holding RAM read returns; head drives the pop data.
// Latency: a push is visible at head/count after the next clk edge.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
module ram_fifo_ob
    import ram_fifo_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [D_WIDTH-1:0]   push_data,
    input  logic                 pop,
    output logic [D_WIDTH-1:0]   head,
    output logic [OB_CNT_W-1:0]  ob_count
);

    logic [D_WIDTH-1:0] mem [0:OB_DEPTH-1];
    logic               wr_idx;
    logic               rd_idx;

    // Storage and write index: entries are cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_idx <= 1'b0;
        end else if (push) begin
            mem[wr_idx] <= push_data;
            wr_idx      <= ~wr_idx;
        end
    end

    // Read index and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_idx   <= 1'b0;
            ob_count <= '0;
        end else begin
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            ob_count <= ob_count + {{(OB_CNT_W-1){1'b0}}, push}
                                 - {{(OB_CNT_W-1){1'b0}}, pop};
        end
    end

    // Head is the oldest entry; it only moves on pop, so it holds under backpressure.
    assign head = mem[rd_idx];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM with a prefetching 2-entry output buffer.
// Latency: out_valid rises 3 edges after an accept into an empty FIFO, counting the accept edge.
// Backpressure: in_ready drops only when the RAM is full; out_ready stall freezes out_data.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_WIDTH-1:0]   out_data,
    output logic                 write_en,
    output logic [A_WIDTH-1:0]   write_addr,
    output logic [D_WIDTH-1:0]   write_data,
    output logic                 read_en,
    output logic [A_WIDTH-1:0]   read_addr,
    input  logic [D_WIDTH-1:0]   read_data,
    output logic [A_WIDTH+1:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 2 ** A_WIDTH;
    localparam int PW    = ptr_w(DEPTH);
    localparam int CW    = cnt_w(DEPTH);

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       ram_cnt;
    logic                inflight;
    logic [OB_CNT_W-1:0] ob_count;
    logic [OB_CNT_W:0]   ob_demand;
    logic                push_fire;
    logic                pop_fire;

    // Occupancy of the RAM alone; the wrap bit makes DEPTH distinguishable from zero.
    assign ram_cnt = wr_ptr - rd_ptr;
    assign full    = (ram_cnt == PW'(DEPTH));
    assign empty   = (count == '0);

    // Push side: space is judged on registered state only, a same-cycle pop does not help.
    assign in_ready   = !full;
    assign push_fire  = in_valid && in_ready;
    assign write_en   = push_fire;
    assign write_addr = wr_ptr[A_WIDTH-1:0];
    assign write_data = in_data;

    // Pop side.
    assign out_valid = (ob_count != '0);
    assign pop_fire  = out_valid && out_ready;

    // Slots the output buffer will need next cycle: held entries plus the return in flight,
    // minus the one leaving now. A read is issued only if that leaves room for its return.
    // pop_fire implies ob_count >= 1, so this cannot underflow.
    assign ob_demand = {1'b0, ob_count}
                     + {{OB_CNT_W{1'b0}}, inflight}
                     - {{OB_CNT_W{1'b0}}, pop_fire};
    assign read_en   = (ram_cnt != '0) && (ob_demand < (OB_CNT_W+1)'(OB_DEPTH));
    assign read_addr = rd_ptr[A_WIDTH-1:0];

    // RAM pointers and the read-in-flight flag; a reset drops any outstanding read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (read_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            inflight <= read_en;
        end
    end

    // Total entries held anywhere: RAM, in flight, and output buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count + {{(CW-1){1'b0}}, push_fire}
                           - {{(CW-1){1'b0}}, pop_fire};
        end
    end

    // Output buffer captures the RAM return the cycle after the read was issued.
    ram_fifo_ob #(
        .D_WIDTH (D_WIDTH)
    ) u_ob (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (read_data),
        .pop       (pop_fire),
        .head      (out_data),
        .ob_count  (ob_count)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural dual-port RAM.
// Latency: n/a.
// Backpressure: exercised with stalls, full conditions and random valid/ready.
module tb_ram_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          read_en;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;

    ram_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read (data the cycle after read_en).
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (write_en) ram[write_addr] <= write_data;
        if (read_en)  read_data <= ram[read_addr];
    end

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] sb[$];
    int cyc = 0;
    int npop = 0;
    int first_pop = 0;
    int last_pop = 0;
    int wraps = 0;
    int max_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: called at a negedge with inputs already driven; samples at +1,
    // updates the scoreboard, then advances to the next negedge.
    task automatic tick();
        logic [DW-1:0] e;
        #1;
        if (rst) begin
            chk("count_vs_model", 64'(count), 64'(sb.size()));
            chk("empty_vs_model", 64'(empty), 64'(sb.size() == 0));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                if (write_addr == 5'd31) wraps++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_underflow", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("pop_data", 64'(out_data), 64'(e));
                end
                if (npop == 0) first_pop = cyc;
                last_pop = cyc;
                npop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [DW-1:0] idat;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [AW+1:0] e_cnt;
        logic          e_emp;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic          e_re;
        logic [AW-1:0] e_ra;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        int word;
        int pushed;
        bit acc;

        // Single word into an empty FIFO: accept edge ends row 0, read issues in row 1,
        // return in flight in row 2, head visible in row 3, drained in row 4.
        vecs[0] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0};
        vecs[1] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        7'd1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd0};
        vecs[2] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        7'd1, 1'b0, 1'b0, 5'd1, 1'b0, 5'd1};
        vecs[3] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 7'd1, 1'b0, 1'b0, 5'd1, 1'b0, 5'd1};
        vecs[4] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 1'b0, 5'd1, 1'b0, 5'd1};

        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_full",      64'(full),      64'(0));
        chk("rst_empty",     64'(empty),     64'(1));
        chk("rst_count",     64'(count),     64'(0));
        chk("rst_write_en",  64'(write_en),  64'(0));
        chk("rst_read_en",   64'(read_en),   64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Table-driven single-word latency sequence.
        for (int i = 0; i < 5; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_data   = vecs[i].idat;
            #1;
            chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov) chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_od));
            chk($sformatf("vec%0d_count", i),     64'(count),     64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_empty", i),     64'(empty),     64'(vecs[i].e_emp));
            chk($sformatf("vec%0d_write_en", i),  64'(write_en),  64'(vecs[i].e_we));
            if (vecs[i].e_we) chk($sformatf("vec%0d_write_addr", i), 64'(write_addr), 64'(vecs[i].e_wa));
            chk($sformatf("vec%0d_read_en", i),   64'(read_en),   64'(vecs[i].e_re));
            if (vecs[i].e_re) chk($sformatf("vec%0d_read_addr", i), 64'(read_addr), 64'(vecs[i].e_ra));
            tick();
        end

        // Fill with out_ready low: DEPTH in RAM plus 2 in the output buffer.
        word = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 60; c++) begin
            in_valid = (word <= 40);
            in_data  = 32'(word);
            acc = in_valid && in_ready;
            tick();
            if (acc) word++;
        end
        in_valid = 1'b0;
        #1;
        chk("fill_accepted",  64'(word),      64'(34));
        chk("fill_in_ready",  64'(in_ready),  64'(0));
        chk("fill_full",      64'(full),      64'(1));
        chk("fill_count",     64'(count),     64'(34));
        chk("fill_out_valid", 64'(out_valid), 64'(1));
        chk("fill_out_data",  64'(out_data),  64'(0));

        // At full, a push and pop in the same cycle: push refused, taken next cycle.
        in_valid = 1'b1;
        in_data = 32'd34;
        out_ready = 1'b1;
        #1;
        chk("fullpop_refused", 64'(in_ready), 64'(0));
        tick();
        out_ready = 1'b0;
        #1;
        chk("fullpop_next_accept", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() != 0; c++) tick();
        chk("fullpop_drained", 64'(sb.size()), 64'(0));

        // Streaming: continuous push and pop of 200 words.
        npop = 0;
        wraps = 0;
        pushed = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 400 && (pushed < 200 || sb.size() != 0); c++) begin
            in_valid = (pushed < 200);
            in_data  = 32'h1000_0000 + 32'(pushed);
            acc = in_valid && in_ready;
            tick();
            if (acc) pushed++;
        end
        in_valid = 1'b0;
        chk("stream_pops",       64'(npop),                 64'(200));
        chk("stream_throughput", 64'(last_pop - first_pop), 64'(199));
        chk("stream_wraps_ge6",  64'(wraps >= 6),           64'(1));

        // Random valid/ready.
        npop = 0;
        pushed = 0;
        max_cnt = 0;
        for (int c = 0; c < 10000 && (pushed < 1000 || sb.size() != 0); c++) begin
            in_valid  = (pushed < 1000) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            in_data   = $urandom;
            acc = in_valid && in_ready;
            tick();
            if (acc) pushed++;
        end
        in_valid = 1'b0;
        chk("random_pushes",  64'(pushed),        64'(1000));
        chk("random_pops",    64'(npop),          64'(1000));
        chk("random_max_cnt", 64'(max_cnt <= 34), 64'(1));

        // Mid-stream reset with 10 entries held.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'hB000_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("pre_reset_count", 64'(count), 64'(10));
        rst = 1'b0;
        #1;
        chk("mrst_count",     64'(count),     64'(0));
        chk("mrst_empty",     64'(empty),     64'(1));
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_in_ready",  64'(in_ready),  64'(1));
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        begin
            int w = 0;
            while (!out_valid && w < 20) begin
                tick();
                w++;
            end
            #1;
            chk("post_reset_valid", 64'(out_valid), 64'(1));
            chk("post_reset_first", 64'(out_data),  64'(32'hA000_0000));
        end
        out_ready = 1'b1;
        for (int c = 0; c < 50 && sb.size() != 0; c++) tick();
        chk("post_reset_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
